// File: rtl/serial_add_sequencer_if.sv
// Operand/result bundle for the bit-serial adder: start handshake, operands,
// busy/done status and the registered result with N/Z/C/V flags.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, a_in, b_in, carry_in, sub,
    input  busy, done, result, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, a_in, b_in, carry_in, sub,
    output busy, done, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full_adder cell produces a WIDTH-bit sum LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds subtraction (A + ~B + 1) on sub=1.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  serial_add_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Operand B and initial carry as loaded on an accepted start.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = bus.sub ? ~bus.b_in : bus.b_in;
  assign carry_load = bus.sub ? 1'b1      : bus.carry_in;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_load     = bus.b_in;
  assign carry_load = bus.carry_in;
`endif

  assign res_full = {fa_sum, res_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sr_d   = bus.a_in;
          b_sr_d   = b_load;
          res_sr_d = '0;
          carry_d  = carry_load;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_full;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        // On the MSB, carry_q is the carry into the MSB, which V needs.
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          result_d = res_full;
          flag_n_d = fa_sum;
          flag_z_d = ~|res_full;
          flag_c_d = fa_cout;
          flag_v_d = carry_q ^ fa_cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.flag_n = flag_n_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_v = flag_v_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: timeline/arithmetic reference model compared
// every cycle, plus directed literal checks and 1000 random back-to-back ops.
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } outs_t;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Plain-arithmetic reference for one operation.
  function automatic outs_t ref_op(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    outs_t        o;
    logic [W:0]   s;
    logic [W-1:0] bb;
    logic         ci;
    bb = b;
    ci = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      bb = ~b;
      ci = 1'b1;
    end
`else
    if (sub) bb = b;
`endif
    s     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    o.res = s[W-1:0];
    o.c   = s[W];
    o.n   = o.res[W-1];
    o.z   = (o.res == '0);
    o.v   = (a[W-1] == bb[W-1]) && (o.res[W-1] != a[W-1]);
    return o;
  endfunction

  // Timeline model: an accepted start makes busy true for W cycles, then done for one.
  int    m_left;
  logic  m_done;
  outs_t m_out;
  outs_t m_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
      m_pend <= '0;
    end else if (m_left == 0 && bus.start) begin
      m_left <= W;
      m_pend <= ref_op(bus.a_in, bus.b_in, bus.carry_in, bus.sub);
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_out  <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  outs_t act;
  always @(negedge clk) begin
    act = {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
    vectors++;
    if (bus.busy !== (m_left > 0) || bus.done !== m_done || act !== m_out) begin
      miscompares++;
      $display("FAIL cycle %0d: busy=%b done=%b out=%h, expected busy=%b done=%b out=%h",
               cyc, bus.busy, bus.done, act, (m_left > 0), m_done, m_out);
    end
  end

  task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", W + 4);
    end
  endtask

  task automatic expect_done(string name, logic [W-1:0] res, logic [3:0] nzcv, output int at);
    wait_done(at);
    if (at >= 0)
      check(name, {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, {res, nzcv});
  endtask

  task automatic set_inputs(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.carry_in = cin;
    bus.sub      = sub;
    bus.start    = 1'b1;
  endtask

  task automatic start_op(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    @(negedge clk);
    set_inputs(a, b, cin, sub);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int at, at2, prev, ndone;
    bus.start    = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.carry_in = 1'b0;
    bus.sub      = 1'b0;

    // Hand-computed pins on the reference model itself.
    check("model_7f_01", ref_op(8'h7F, 8'h01, 1'b0, 1'b0), {8'h80, 4'b1001});
    check("model_ff_01", ref_op(8'hFF, 8'h01, 1'b0, 1'b0), {8'h00, 4'b0110});
    check("model_00_cin", ref_op(8'h00, 8'h00, 1'b1, 1'b0), {8'h01, 4'b0000});

    #2 reset_n = 1'b0;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_outs", {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    expect_done("add_7f_01", 8'h80, 4'b1001, at);
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    expect_done("add_ff_01", 8'h00, 4'b0110, at);
    start_op(8'h00, 8'h00, 1'b1, 1'b0);
    expect_done("add_00_cin", 8'h01, 4'b0000, at);

    // Start during RUN is ignored; start held in the DONE cycle is accepted.
    start_op(8'h20, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    bus.a_in  = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    expect_done("ignored_start", 8'h23, 4'b0000, at);
    set_inputs(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    expect_done("b2b_add", 8'h30, 4'b0000, at2);
    check("b2b_spacing", at2 - at, W + 1);

`ifdef SERIAL_ADD_SUB_EN
    start_op(8'h05, 8'h05, 1'b0, 1'b1);
    expect_done("sub_05_05", 8'h00, 4'b0110, at);
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    expect_done("sub_80_01", 8'h7F, 4'b0011, at);
`else
    start_op(8'h05, 8'h05, 1'b0, 1'b1);
    expect_done("sub_ignored", 8'h0A, 4'b0000, at);
`endif

    // Asynchronous reset after three bits of a RUN.
    start_op(8'h0F, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_busy", bus.busy, 0);
    check("midrun_done", bus.done, 0);
    check("midrun_outs", {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    expect_done("after_reset_add", 8'h46, 4'b0000, at);

    // Random back-to-back stream; the per-cycle compare checks every value.
    start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_done(at);
      if (at < 0) break;
      if (i > 0) check("rand_spacing", at - prev, W + 1);
      prev = at;
      if (i < 999) begin
        set_inputs(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        bus.start = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Bit-serial adder controller: time-shares a single full_adder cell to compute a WIDTH-bit sum one bit per clock, LSB first. Accepts operands on a start/busy/done handshake, runs a 3-state FSM, shifts operands and result through registers, and holds the carry between bits in a flip-flop. Reports CPU-style N/Z/C/V flags. Intended as the low-area ALU add path and the PC/address incrementer alternative in PepeCPU.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64
CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a_in  input  WIDTH  operand A, captured on accepted start
b_in  input  WIDTH  operand B, captured on accepted start
carry_in  input  1  initial carry, captured on accepted start
sub  input  1  subtract request (see Optional Feature)
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result and flags are valid
result  output  WIDTH  sum; held stable from done until next accepted start
flag_n  output  1  result[WIDTH-1]
flag_z  output  1  result == 0
flag_c  output  1  carry out of MSB
flag_v  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). On assert: state=IDLE; busy, done, result, all flags, bit counter, carry FF, and operand shift registers = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load A/B shift regs, carry FF <= carry_in, counter <= 0, go RUN.
  - RUN: each cycle, full_adder sees A_sr[0], B_sr[0], carry FF; sum bit shifts into result_sr MSB (result_sr shifts right); A/B shift right; carry FF <= carry_out; counter++. When counter == WIDTH-1 (last bit), go DONE; carry into MSB captured that cycle for V.
  - DONE: done=1 for exactly this cycle; result/flags update on entry. If start=1 in DONE, accepted exactly as in IDLE (back-to-back, next RUN begins the following cycle). Otherwise go IDLE.
- Latency: start accepted at edge k -> busy high cycles k+1..k+WIDTH -> done high cycle k+WIDTH+1. Throughput: one op per WIDTH+1 cycles.
- busy = (state==RUN). done and busy never high together.
- start while RUN is ignored; no queuing; operands on a_in/b_in ignored.
- result and flags are registered outputs; they change only on entering DONE; hold through IDLE and the following RUN.
- Reset mid-RUN: operation discarded, no done pulse, outputs zero.
- WIDTH-bit wrap: overflow beyond MSB appears only in flag_c; result is modulo 2^WIDTH.
- The adder cell is the existing combinational full_adder, instantiated once; no other adder logic.

Optional Feature:
SERIAL_ADD_SUB_EN. Defined: on accepted start with sub=1, B shift reg loads ~b_in and carry FF loads 1 (carry_in ignored); result = A - B, flag_c = NOT borrow (ARM convention), flag_v per signed subtraction. With sub=0, plain add. Not defined: sub port is present but ignored; always A + B + carry_in; no inversion logic is synthesised.

Test Plan:
- WIDTH=8, reset_n low mid-RUN after 3 bits -> busy/done/result/flags all 0 immediately (async); no done pulse after release; next start completes normally.
- a=0x7F, b=0x01, cin=0, start one cycle -> busy for 8 cycles, done on cycle 9: result=0x80, N=1 Z=0 C=0 V=1.
- a=0xFF, b=0x01, cin=0 -> result=0x00, N=0 Z=1 C=1 V=0; then a=0x00, b=0x00, cin=1 -> result=0x01, Z=0.
- Start pulsed again at cycle 3 of RUN with a=0x11 -> ignored; original result delivered; start held in DONE cycle with a=0x10,b=0x20 -> next done 9 cycles later with result=0x30.
- With SERIAL_ADD_SUB_EN: sub=1, a=0x05, b=0x05 -> result=0x00, Z=1 C=1 V=0; sub=1, a=0x80, b=0x01 -> result=0x7F, V=1 C=1 N=0. Without macro: sub=1, a=0x05, b=0x05 -> result=0x0A.
- Back-to-back random: 1000 ops, start asserted in every DONE cycle -> each done exactly WIDTH+1 cycles apart; result/flags match reference model.
